// File: rtl/key_debounce.sv
// Two-key debouncer: per-key 2-flop synchronizer plus debounce FSM producing level, press and release.
// Optional auto-repeat of key_press_o while held: define KEY_DEBOUNCE_REPEAT_EN.
`timescale 1ns/1ps

module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic       clk100_i,
    input  logic       rst_i,
    input  logic [1:0] key_i,
    output logic [1:0] key_state_o,
    output logic [1:0] key_press_o,
    output logic [1:0] key_release_o
);

    localparam int unsigned NUM_KEYS = 2;
    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    // Reject parameter values outside their legal range at elaboration.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32'h00FF_FFFF) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES out of range");
    end
    if (HOLD_W < 1) begin : g_bad_hold
        $error("key_debounce: HOLD_CYCLES/REPEAT_CYCLES must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
        logic             sync_q1;
        logic             s;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             state_q;
        logic             press_q;
        logic             release_q;

        // Keys are active-low; synchronizer holds the active-high pressed level.
        always_ff @(posedge clk100_i) begin
            if (rst_i) begin
                sync_q1 <= 1'b0;
                s       <= 1'b0;
            end else begin
                sync_q1 <= ~key_i[k];
                s       <= sync_q1;
            end
        end

`ifdef KEY_DEBOUNCE_REPEAT_EN
        logic [HOLD_W-1:0] hold_cnt;
        logic              repeating;
        logic [HOLD_W-1:0] hold_last_c;

        assign hold_last_c = repeating ? HOLD_W'(REPEAT_CYCLES - 1) : HOLD_W'(HOLD_CYCLES - 1);
`endif

        always_ff @(posedge clk100_i) begin
            if (rst_i) begin
                state     <= IDLE;
                cnt       <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                hold_cnt  <= '0;
                repeating <= 1'b0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s) begin
                            state <= PRESS_WAIT;
                            cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s) begin
                            state <= IDLE;
                        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                            state   <= PRESSED;
                            state_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!s) begin
                            state <= RELEASE_WAIT;
                            cnt   <= '0;
                        end
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        // Hold time only advances while the key is cleanly held.
                        else if (hold_cnt == hold_last_c) begin
                            press_q   <= 1'b1;
                            hold_cnt  <= '0;
                            repeating <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        if (s) begin
                            state <= PRESSED;
                        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                            state     <= IDLE;
                            state_q   <= 1'b0;
                            release_q <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                            hold_cnt  <= '0;
                            repeating <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign key_state_o[k]   = state_q;
        assign key_press_o[k]   = press_q;
        assign key_release_o[k] = release_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: run-length reference model predicts pulses, monitor compares.
`timescale 1ns/1ps

module tb_key_debounce;

    localparam int unsigned D = 4;
    localparam int unsigned H = 20;
    localparam int unsigned R = 8;

    logic       clk100_i = 1'b0;
    logic       rst_i;
    logic [1:0] key_i;
    logic [1:0] key_state_o;
    logic [1:0] key_press_o;
    logic [1:0] key_release_o;

    always #5 clk100_i = ~clk100_i;

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk100_i     (clk100_i),
        .rst_i        (rst_i),
        .key_i        (key_i),
        .key_state_o  (key_state_o),
        .key_press_o  (key_press_o),
        .key_release_o(key_release_o)
    );

    typedef struct {
        int unsigned cyc;
        logic [1:0]  press;
        logic [1:0]  rel;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          started = 0;

    // Reference model: a level change is accepted once the synchronized key has
    // disagreed with the accepted level on D+1 consecutive edges.
    logic [1:0]  m_s1 = '0;
    logic [1:0]  m_s2 = '0;
    logic [1:0]  m_acc = '0;
    logic [1:0]  exp_state = '0;
    int unsigned m_run[2] = '{0, 0};
`ifdef KEY_DEBOUNCE_REPEAT_EN
    int unsigned m_hold[2] = '{0, 0};
`endif

    always @(posedge clk100_i) begin
        logic [1:0] s;
        logic [1:0] pr;
        logic [1:0] rl;
        cyc = cyc + 1;
        if (rst_i) begin
            m_s1      = '0;
            m_s2      = '0;
            m_acc     = '0;
            m_run     = '{0, 0};
            exp_state = '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
            m_hold    = '{0, 0};
`endif
        end else begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = ~key_i;
            pr   = '0;
            rl   = '0;
            for (int k = 0; k < 2; k++) begin
                if (s[k] != m_acc[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == D + 1) begin
                        m_acc[k] = s[k];
                        m_run[k] = 0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                        m_hold[k] = 0;
`endif
                        if (s[k]) pr[k] = 1'b1;
                        else      rl[k] = 1'b1;
                    end
                end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
                    if (m_run[k] == 0 && m_acc[k]) begin
                        m_hold[k] = m_hold[k] + 1;
                        if (m_hold[k] == H || (m_hold[k] > H && (m_hold[k] - H) % R == 0))
                            pr[k] = 1'b1;
                    end
`endif
                    m_run[k] = 0;
                end
            end
            if ((pr | rl) != 2'b00) exp_q.push_back('{cyc, pr, rl});
            exp_state = m_acc;
        end
    end

    // Monitor: compare level every cycle, match each pulse against the scoreboard.
    always @(negedge clk100_i) begin
        if (started) begin
            vectors++;
            if (key_state_o !== exp_state) begin
                miscompares++;
                $display("FAIL key_state cyc=%0d got=%b exp=%b", cyc, key_state_o, exp_state);
            end
            if ((key_press_o | key_release_o) !== 2'b00) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse cyc=%0d got press=%b rel=%b exp none",
                             cyc, key_press_o, key_release_o);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.press !== key_press_o || e.rel !== key_release_o) begin
                        miscompares++;
                        $display("FAIL pulse cyc=%0d got press=%b rel=%b exp cyc=%0d press=%b rel=%b",
                                 cyc, key_press_o, key_release_o, e.cyc, e.press, e.rel);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                ev_t e;
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed_pulse cyc=%0d got none exp cyc=%0d press=%b rel=%b",
                         cyc, e.cyc, e.press, e.rel);
            end
        end
    end

    task automatic hold_keys(input logic [1:0] k, input int n);
        key_i = k;
        repeat (n) @(negedge clk100_i);
    endtask

    int          dur[2];
    logic [1:0]  lvl;

    initial begin
        rst_i = 1'b1;
        key_i = 2'b11;
        repeat (3) @(posedge clk100_i);
        @(negedge clk100_i);
        started = 1'b1;
        rst_i   = 1'b0;

        hold_keys(2'b11, 10);
        hold_keys(2'b10, 30);                          // clean press of key 0
        hold_keys(2'b11, 15);
        hold_keys(2'b10, 3);                           // glitch shorter than debounce
        hold_keys(2'b11, 10);
        hold_keys(2'b10, 20);                          // press, bounce, release
        hold_keys(2'b11, 2);
        hold_keys(2'b10, 5);
        hold_keys(2'b11, 15);
        hold_keys(2'b00, 15);                          // both keys together
        hold_keys(2'b11, 15);
        hold_keys(2'b10, 3);                           // reset during press debounce
        rst_i = 1'b1;
        @(negedge clk100_i);
        rst_i = 1'b0;
        hold_keys(2'b10, 20);
        hold_keys(2'b11, 15);
        hold_keys(2'b10, 60);                          // long hold
        hold_keys(2'b11, 15);

        dur = '{0, 0};
        lvl = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (dur[k] == 0) begin
                    lvl[k] = 1'($urandom_range(0, 1));
                    dur[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 60))
                                                         : int'($urandom_range(1, 8));
                end
                dur[k] = dur[k] - 1;
            end
            key_i = lvl;
            rst_i = ($urandom_range(0, 399) == 0);
            @(negedge clk100_i);
        end

        rst_i = 1'b0;
        hold_keys(2'b11, 20);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_events got %0d pending exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
